// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM state encoding and oversampling constants.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int unsigned OVERSAMPLE     = 16;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned MID_TICK       = 7;
    localparam int unsigned TICK_W         = $clog2(OVERSAMPLE);
    localparam int unsigned IDX_W          = $clog2(BYTES_PER_WORD);
    localparam int unsigned WORD_W         = 8 * BYTES_PER_WORD;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        RX_PARITY    = 3'd3,
`endif
        RX_STOP      = 3'd4,
        RX_WAIT_HIGH = 3'd5
    } uart_rx_state_t;

endpackage

// File: rtl/baud_tick_gen.sv
// Divides clk down to a one-cycle tick at BAUD*OVERSAMPLE (rounded to nearest).
// Reused by the transmitter with OVERSAMPLE = 1.
module baud_tick_gen #(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned DIV_RAW = (CLK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
    localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CNT_W'(DIV - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CNT_W'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_word.sv
// 16x oversampled UART receiver assembling four LSB-first bytes into a 32-bit word.
// Define UART_RX_PARITY_EN for a 9th even-parity bit per frame.
module uart_rx_word
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned BAUD         = 9600,
    parameter int unsigned TIMEOUT_BITS = 40
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Rx,
    output logic [WORD_W-1:0] Dato,
    output logic              listo,
    output logic              error,
    output logic              busy
);

    localparam int unsigned TO_LIMIT = ((TIMEOUT_BITS < 1) ? 1 : TIMEOUT_BITS) * OVERSAMPLE;
    localparam int unsigned TO_W     = $clog2(TO_LIMIT);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] MID       = TICK_W'(MID_TICK);

    uart_rx_state_t    state, state_n;
    logic              rx_meta, rx_sync, rx_prev;
    logic              tick, tick_rst, fall;
    logic [TICK_W-1:0] tick_cnt, tick_cnt_n;
    logic [2:0]        bit_cnt, bit_cnt_n;
    logic [7:0]        shift, shift_n;
    logic [IDX_W-1:0]  byte_idx, byte_idx_n;
    logic [WORD_W-1:0] staging, staging_n, dato_n;
    logic [TO_W-1:0]   to_cnt, to_cnt_n;
    logic              listo_n, error_n, busy_n;
    logic              accept, frame_err;

    assign fall     = rx_prev & ~rx_sync;
    // Restart the divider on a start edge so mid-bit samples stay centred
    assign tick_rst = reset | ((state == RX_IDLE) & fall);

    baud_tick_gen #(
        .CLK_HZ    (CLK_HZ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_tick (
        .clk  (clk),
        .reset(tick_rst),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            state    <= RX_IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            byte_idx <= '0;
            staging  <= '0;
            to_cnt   <= '0;
            Dato     <= '0;
            listo    <= 1'b0;
            error    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            rx_meta  <= Rx;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            state    <= state_n;
            tick_cnt <= tick_cnt_n;
            bit_cnt  <= bit_cnt_n;
            shift    <= shift_n;
            byte_idx <= byte_idx_n;
            staging  <= staging_n;
            to_cnt   <= to_cnt_n;
            Dato     <= dato_n;
            listo    <= listo_n;
            error    <= error_n;
            busy     <= busy_n;
        end
    end

    always_comb begin
        state_n    = state;
        tick_cnt_n = tick_cnt;
        bit_cnt_n  = bit_cnt;
        shift_n    = shift;
        byte_idx_n = byte_idx;
        staging_n  = staging;
        to_cnt_n   = to_cnt;
        dato_n     = Dato;
        listo_n    = 1'b0;
        error_n    = 1'b0;
        accept     = 1'b0;
        frame_err  = 1'b0;

        case (state)
            RX_IDLE: begin
                tick_cnt_n = '0;
                bit_cnt_n  = '0;
                // Inter-byte timeout; evaluated before the edge so expiry wins a tie
                if (byte_idx != '0) begin
                    if (tick) begin
                        if (to_cnt == TO_W'(TO_LIMIT - 1)) begin
                            byte_idx_n = '0;
                            staging_n  = '0;
                            to_cnt_n   = '0;
                        end else begin
                            to_cnt_n = to_cnt + TO_W'(1);
                        end
                    end
                end else begin
                    to_cnt_n = '0;
                end
                if (fall) begin
                    state_n  = RX_START;
                    to_cnt_n = '0;
                end
            end

            RX_START: begin
                if (tick) begin
                    if (tick_cnt == MID) begin
                        tick_cnt_n = '0;
                        state_n    = rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        tick_cnt_n = tick_cnt + TICK_W'(1);
                    end
                end
            end

            RX_DATA: begin
                if (tick) begin
                    if (tick_cnt == LAST_TICK) begin
                        tick_cnt_n = '0;
                        shift_n    = {rx_sync, shift[7:1]};
                        bit_cnt_n  = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_n = RX_PARITY;
`else
                            state_n = RX_STOP;
`endif
                        end
                    end else begin
                        tick_cnt_n = tick_cnt + TICK_W'(1);
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
                if (tick) begin
                    if (tick_cnt == LAST_TICK) begin
                        tick_cnt_n = '0;
                        if (rx_sync != ^shift) begin
                            frame_err = 1'b1;
                        end else begin
                            state_n = RX_STOP;
                        end
                    end else begin
                        tick_cnt_n = tick_cnt + TICK_W'(1);
                    end
                end
            end
`endif

            RX_STOP: begin
                if (tick) begin
                    if (tick_cnt == LAST_TICK) begin
                        tick_cnt_n = '0;
                        if (rx_sync) begin
                            accept  = 1'b1;
                            state_n = RX_IDLE;
                        end else begin
                            frame_err = 1'b1;
                        end
                    end else begin
                        tick_cnt_n = tick_cnt + TICK_W'(1);
                    end
                end
            end

            RX_WAIT_HIGH: begin
                if (rx_sync) begin
                    state_n = RX_IDLE;
                end
            end

            default: begin
                state_n = RX_IDLE;
            end
        endcase

        // Bad frame discards the partial word and waits for the line to recover
        if (frame_err) begin
            error_n    = 1'b1;
            staging_n  = '0;
            byte_idx_n = '0;
            state_n    = RX_WAIT_HIGH;
        end

        if (accept) begin
            staging_n[{byte_idx, 3'b000} +: 8] = shift;
            if (byte_idx == IDX_W'(BYTES_PER_WORD - 1)) begin
                dato_n     = staging_n;
                listo_n    = 1'b1;
                staging_n  = '0;
                byte_idx_n = '0;
            end else begin
                byte_idx_n = byte_idx + IDX_W'(1);
            end
        end

        busy_n = (byte_idx_n != '0) || !((state_n == RX_IDLE) || (state_n == RX_WAIT_HIGH));
    end

endmodule

// File: tb/tb_uart_rx_word.sv
// Scoreboard bench for uart_rx_word at a scaled-down baud (4 clocks per tick, 64 per bit).
// Also exercises parity when UART_RX_PARITY_EN is defined.
module tb_uart_rx_word;

    localparam int unsigned TB_CLK_HZ = 6_400_000;
    localparam int unsigned TB_BAUD   = 100_000;
    localparam int unsigned BIT_CLKS  = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Rx = 1'b1;
    logic [31:0] Dato;
    logic        listo;
    logic        error;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int listo_cnt = 0;
    int err_cnt = 0;
    logic [31:0] exp_q[$];

    uart_rx_word #(
        .CLK_HZ      (TB_CLK_HZ),
        .BAUD        (TB_BAUD),
        .TIMEOUT_BITS(40)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .Rx   (Rx),
        .Dato (Dato),
        .listo(listo),
        .error(error),
        .busy (busy)
    );

    always #5 clk = ~clk;

    // Scoreboard: every listo pops the oldest expected word
    always @(negedge clk) begin
        logic [31:0] exp_w;
        if (!reset) begin
            if (listo) begin
                listo_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL listo_unexpected got Dato=%h expected no word", Dato);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (Dato !== exp_w) begin
                        failures++;
                        $display("FAIL word_value got %h expected %h", Dato, exp_w);
                    end
                end
                checks++;
                if (error !== 1'b0) begin
                    failures++;
                    $display("FAIL listo_error_overlap got error=%b expected 0", error);
                end
            end
            if (error) err_cnt++;
        end
    end

    task automatic send_bit(input logic v);
        Rx = v;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        Rx = 1'b1;
        repeat (n * BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^b);
`endif
        send_bit(stop_v);
        Rx = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        exp_q.push_back(w);
        for (int i = 0; i < 4; i++) send_frame(w[8*i +: 8], 1'b1);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 4 * BIT_CLKS && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain got %0d pending words expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        Rx = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (Dato !== 32'h0) begin failures++; $display("FAIL reset_dato got %h expected 0", Dato); end
        checks++; if (listo !== 1'b0) begin failures++; $display("FAIL reset_listo got %b expected 0", listo); end
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL reset_error got %b expected 0", error); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b expected 0", busy); end
        idle_bits(1);
    endtask

    task automatic test_nominal();
        int l0, e0;
        l0 = listo_cnt; e0 = err_cnt;
        send_word(32'hDEADBEEF);
        wait_drain("nominal");
        idle_bits(1);
        checks++; if (Dato !== 32'hDEADBEEF) begin failures++; $display("FAIL nominal_dato got %h expected deadbeef", Dato); end
        checks++; if (listo_cnt - l0 != 1) begin failures++; $display("FAIL nominal_listo_count got %0d expected 1", listo_cnt - l0); end
        checks++; if (err_cnt != e0) begin failures++; $display("FAIL nominal_error got %0d expected 0", err_cnt - e0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL nominal_busy got %b expected 0", busy); end
    endtask

    task automatic test_glitch();
        int l0, e0;
        l0 = listo_cnt; e0 = err_cnt;
        Rx = 1'b0;
        repeat (16) @(negedge clk);
        idle_bits(2);
        checks++; if (listo_cnt != l0 || err_cnt != e0) begin failures++; $display("FAIL glitch_flags got listo=%0d error=%0d expected 0 0", listo_cnt - l0, err_cnt - e0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL glitch_busy got %b expected 0", busy); end
        send_word(32'h12345678);
        wait_drain("glitch");
        checks++; if (Dato !== 32'h12345678) begin failures++; $display("FAIL glitch_dato got %h expected 12345678", Dato); end
        idle_bits(1);
    endtask

    task automatic test_framing();
        int l0, e0;
        l0 = listo_cnt; e0 = err_cnt;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b0);
        idle_bits(3);
        checks++; if (err_cnt - e0 != 1) begin failures++; $display("FAIL framing_error_count got %0d expected 1", err_cnt - e0); end
        checks++; if (listo_cnt != l0) begin failures++; $display("FAIL framing_listo got %0d expected 0", listo_cnt - l0); end
        checks++; if (Dato !== 32'h12345678) begin failures++; $display("FAIL framing_dato_held got %h expected 12345678", Dato); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL framing_busy got %b expected 0", busy); end
        send_word(32'h01020304);
        wait_drain("framing");
        checks++; if (Dato !== 32'h01020304) begin failures++; $display("FAIL framing_recover got %h expected 01020304", Dato); end
        idle_bits(1);
    endtask

    task automatic test_timeout();
        int e0;
        e0 = err_cnt;
        send_frame(8'hAA, 1'b1);
        send_frame(8'hBB, 1'b1);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL timeout_busy_partial got %b expected 1", busy); end
        idle_bits(38);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL timeout_busy_early got %b expected 1", busy); end
        idle_bits(3);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL timeout_busy_drop got %b expected 0", busy); end
        checks++; if (Dato !== 32'h01020304) begin failures++; $display("FAIL timeout_dato_held got %h expected 01020304", Dato); end
        idle_bits(9);
        send_word(32'h12345678);
        wait_drain("timeout");
        checks++; if (Dato !== 32'h12345678) begin failures++; $display("FAIL timeout_dato got %h expected 12345678", Dato); end
        checks++; if (err_cnt != e0) begin failures++; $display("FAIL timeout_error got %0d expected 0", err_cnt - e0); end
        idle_bits(1);
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        b = 8'hFE;
        send_frame(8'h0D, 1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(b[i]);
        Rx = b[3];
        repeat (BIT_CLKS / 2) @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midreset_busy_before got %b expected 1", busy); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        Rx = 1'b1;
        checks++; if (Dato !== 32'h0) begin failures++; $display("FAIL midreset_dato got %h expected 0", Dato); end
        checks++; if (busy !== 1'b0 || listo !== 1'b0 || error !== 1'b0) begin failures++; $display("FAIL midreset_flags got busy=%b listo=%b error=%b expected 0 0 0", busy, listo, error); end
        idle_bits(2);
        send_word(32'hCAFEF00D);
        wait_drain("midreset");
        checks++; if (Dato !== 32'hCAFEF00D) begin failures++; $display("FAIL midreset_dato_after got %h expected cafef00d", Dato); end
        idle_bits(1);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int l0, e0;
        logic [7:0] b;
        l0 = listo_cnt; e0 = err_cnt;
        b = 8'h03;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(1'b1);
        send_bit(1'b1);
        idle_bits(2);
        checks++; if (err_cnt - e0 != 1) begin failures++; $display("FAIL parity_error_count got %0d expected 1", err_cnt - e0); end
        checks++; if (listo_cnt != l0) begin failures++; $display("FAIL parity_listo got %0d expected 0", listo_cnt - l0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL parity_busy got %b expected 0", busy); end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_nominal();
        test_glitch();
        test_framing();
        test_timeout();
        test_reset_mid();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_word.md
# uart_rx_word

Serial receiver for the board's UART link. It is the counterpart of the 32-bit word transmitter. It oversamples the `Rx` line at 16× baud and decodes 8N1 frames. It assembles four consecutive bytes, least significant byte first, into a 32-bit word and presents it on `Dato` with a one-cycle `listo` strobe. It sits between the pin synchroniser-free top level and the register or controller logic that consumes received words.

## Interface
- `CLK_HZ`, default 100_000_000: system clock frequency.
- `BAUD`, default 9600: line bit rate.
- `TIMEOUT_BITS`, default 40: maximum idle gap between bytes of one word, in bit times, before a partial word is discarded.
- `clk` input, 1 bit: system clock. Everything runs on its rising edge.
- `reset` input, 1 bit: synchronous, active-high reset.
- `Rx` input, 1 bit: asynchronous serial line, idle high.
- `Dato` output, 32 bits: last complete word, held until the next word completes. Resets to 0.
- `listo` output, 1 bit: one-cycle pulse when `Dato` updates. Resets to 0.
- `error` output, 1 bit: one-cycle pulse on a framing error (or parity error, see Configuration). Resets to 0.
- `busy` output, 1 bit: high while a word is partially received. Resets to 0.

## Operation
- **Input synchronisation:** `Rx` passes through a 2-flop synchroniser (reset value 1). All decoding uses the synchronised value.
- **Tick generation:** a tick divider produces a 1-cycle `tick` every `DIV = round(CLK_HZ/(BAUD*16))` clocks. With the defaults, DIV = 651.
- **FSM states:** IDLE, START, DATA, PARITY (only when the macro is set), STOP, WAIT_HIGH.
- **IDLE:** a synchronised falling edge goes to START and clears the tick counter.
- **START:** at tick count 7 (mid-bit), a sampled 0 goes to DATA. A sampled 1 is a glitch: return to IDLE with no flags.
- **DATA:** the line is sampled every 16 ticks, at mid-bit. Bits are shifted in LSB first. After 8 bits, go to PARITY or STOP.
- **STOP:** at mid-bit, a sample of 1 accepts the byte. A sample of 0 triggers the framing-error path:
  - pulse `error`;
  - discard the partial word;
  - reset the byte index;
  - go to WAIT_HIGH.
- **WAIT_HIGH:** return to IDLE once the synchronised line reads 1.
- **Byte assembly:** accepted byte n (n = 0..3) goes to bits [8n+7:8n] of a staging register.
  - After byte 3, copy the staging register to `Dato`, pulse `listo` and clear the byte index.
- **busy:** high while byte index ≠ 0, or while the FSM is outside IDLE and WAIT_HIGH.
- **Inter-byte timeout:**
  - While byte index ≠ 0 and the FSM is in IDLE, a counter counts ticks.
  - At TIMEOUT_BITS×16 ticks: clear the byte index, drop the staging register and drop `busy`. No `error` is raised.
  - The counter clears on each falling edge.
- **Reset:** at any point, including mid-byte, reset returns the FSM to IDLE and clears the staging register, `Dato`, the counters and all outputs. The next valid start bit is received normally.

## Timing
- **Start-bit latency:** 2 clocks of synchroniser delay, then validation 8 ticks after the edge.
- **`listo` timing:** `listo` and the new `Dato` appear on the clock after the 4th byte's stop-bit sample. Both update in the same cycle.
- **`error` timing:** `error` appears on the clock after the failing stop-bit (or parity) sample.
- **Simultaneous events:** `listo` and `error` are never high together.
- **Timeout vs. start edge:** if the timeout expires on the same cycle as a falling edge, the timeout wins. The edge then starts byte 0 of a new word.
- **Back-to-back frames:** a new start edge is accepted in the clock right after STOP completes, so there is no dead time.

## Configuration
- `UART_RX_PARITY_EN` defined: a 9th bit, even parity, follows the 8 data bits.
  - It is sampled mid-bit in PARITY.
  - A mismatch pulses `error`, discards the word and goes to WAIT_HIGH.
- `UART_RX_PARITY_EN` undefined: there is no PARITY state. The frame is 8N1.

## Structure
- **Shared package `uart_pkg`:**
  - the state enum `uart_rx_state_t`;
  - `OVERSAMPLE = 16`;
  - `BYTES_PER_WORD = 4`;
  - the mid-bit constant `MID_TICK = 7`.
- **Sub-module `baud_tick_gen`:** parameters CLK_HZ, BAUD and OVERSAMPLE. Ports `clk`, `reset` and `tick`. A synchronous `reset` clears its counter.
- **Reuse:** the transmitter side can reuse `baud_tick_gen` with OVERSAMPLE = 1.

## Test plan
- **Nominal word:** send bytes EF, BE, AD, DE back-to-back at 9600 baud. Require `Dato` = 0xDEADBEEF, exactly one `listo` pulse, no `error`, and `busy` low afterwards.
- **Start glitch:** hold `Rx` low for 4 ticks (~2600 clocks), then send 78, 56, 34, 12. Require no reception from the glitch, then `Dato` = 0x12345678.
- **Framing error:** send byte 11, then byte 22 with stop bit = 0. Require one `error` pulse, no `listo` and unchanged `Dato`. Then send 04, 03, 02, 01 and require `Dato` = 0x01020304.
- **Timeout:** send AA, BB, then idle for 50 bit times, then send 78, 56, 34, 12. Require that `busy` drops after 40 bit times and that `Dato` = 0x12345678.
- **Reset mid-operation:** assert `reset` for 1 clock during bit 3 of byte 1. Require all outputs 0 on the next clock, then a correct reception of 0xCAFEF00D.
- **Parity error (with `UART_RX_PARITY_EN`):** send byte 0x03 with parity = 1. Require an `error` pulse and no `listo`.
